// File: rtl/regfile_host_arb.sv
// regfile_host_arb: shares regfile write port 0 between core and host debug port with starvation stall; REGFILE_HOST_ARB_FWD_EN forwards same-cycle writes into host reads
module regfile_host_arb #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_host_req_valid,
  output logic              io_host_req_ready,
  input  logic              io_host_req_rw,
  input  logic [ADDR_W-1:0] io_host_req_adr,
  input  logic [DATA_W-1:0] io_host_req_dat,
  output logic              io_host_resp_valid,
  input  logic              io_host_resp_ready,
  output logic [DATA_W-1:0] io_host_resp_dat,
  input  logic              io_core_wr_is,
  input  logic [ADDR_W-1:0] io_core_wr_adr,
  input  logic [DATA_W-1:0] io_core_wr_dat,
  output logic              io_core_stall,
  output logic              io_rf_wr_is,
  output logic [ADDR_W-1:0] io_rf_wr_adr,
  output logic [DATA_W-1:0] io_rf_wr_dat,
  output logic [ADDR_W-1:0] io_rf_rd_adr,
  input  logic [DATA_W-1:0] io_rf_rd_dat
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic rw_q, rw_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d, resp_q, resp_d;
  logic host_grant;
  always_comb begin
    host_grant = state_q == WRITE && !reset && (!io_core_wr_is || starve_q == 4'(STARVE_LIMIT));
    io_core_stall = host_grant && io_core_wr_is;
    io_rf_wr_is = host_grant || io_core_wr_is;
    io_rf_wr_adr = host_grant ? adr_q : io_core_wr_adr;
    io_rf_wr_dat = host_grant ? dat_q : io_core_wr_dat;
    io_rf_rd_adr = adr_q;
    io_host_req_ready = state_q == IDLE;
    io_host_resp_valid = state_q == RESP;
    io_host_resp_dat = resp_q;
    state_d = state_q;
    starve_d = starve_q;
    rw_d = rw_q;
    adr_d = adr_q;
    dat_d = dat_q;
    resp_d = resp_q;
    unique case (state_q)
      IDLE: if (io_host_req_valid) begin
        rw_d = io_host_req_rw;
        adr_d = io_host_req_adr;
        dat_d = io_host_req_dat;
        state_d = io_host_req_rw ? WRITE : READ;
      end
      READ: begin
`ifdef REGFILE_HOST_ARB_FWD_EN
        resp_d = (io_core_wr_is && io_core_wr_adr == adr_q) ? io_core_wr_dat : io_rf_rd_dat;
`else
        resp_d = io_rf_rd_dat;
`endif
        state_d = RESP;
      end
      WRITE: if (host_grant) begin
        resp_d = dat_q;
        starve_d = '0;
        state_d = RESP;
      end else starve_d = starve_q + 4'd1;
      RESP: if (io_host_resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      starve_q <= '0;
      rw_q <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      resp_q <= '0;
    end else begin
      state_q <= state_d;
      starve_q <= starve_d;
      rw_q <= rw_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      resp_q <= resp_d;
    end
  end
endmodule
